// File: rtl/tag_fifo_if.sv
// rtl/tag_fifo_if.sv - dispatch allocate and CDB release bundle for tag_fifo
interface tag_fifo_if #(
    parameter int TAG_W = 6
);
    logic             alloc_req;
    logic             alloc_valid;
    logic [TAG_W-1:0] alloc_tag;
    logic [TAG_W:0]   alloc_wdata;
    logic             cdb_valid;
    logic [TAG_W-1:0] cdb_tag;

    // dispatch / CDB side
    modport master (
        output alloc_req, cdb_valid, cdb_tag,
        input  alloc_valid, alloc_tag, alloc_wdata
    );

    // free-list side
    modport slave (
        input  alloc_req, cdb_valid, cdb_tag,
        output alloc_valid, alloc_tag, alloc_wdata
    );
endinterface

// File: rtl/tag_fifo.sv
// rtl/tag_fifo.sv - rename-tag free list (optional CDB bypass: TAG_FIFO_BYPASS_EN)
module tag_fifo #(
    parameter int TAG_W    = 6,
    parameter int NUM_TAGS = 63,
    parameter int CNT_W    = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    tag_fifo_if.slave        bus,
    output logic [CNT_W-1:0] free_count,
    output logic             overflow_err,
    output logic             zero_tag_err
);
    localparam int PTR_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

    logic [TAG_W-1:0] mem [NUM_TAGS];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;

    logic empty;
    logic full;
    logic rel_tag_ok;
    logic bypass;
    logic bypass_take;
    logic alloc_fire;
    logic rel_fire;
    logic ovf_set;
    logic zte_set;

    // Pointers wrap explicitly so NUM_TAGS need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_TAGS - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty      = (free_count == '0);
    assign full       = (free_count == CNT_W'(NUM_TAGS));
    assign rel_tag_ok = bus.cdb_valid && (bus.cdb_tag != '0);

`ifdef TAG_FIFO_BYPASS_EN
    assign bypass = empty && rel_tag_ok;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed tag goes straight to dispatch and never touches storage.
    assign bypass_take = bypass && bus.alloc_req;
    assign alloc_fire  = bus.alloc_req && !empty;
    // An allocate in the same cycle opens a slot, so a full list still accepts.
    assign rel_fire    = rel_tag_ok && (!full || alloc_fire) && !bypass_take;
    assign ovf_set     = rel_tag_ok && full && !alloc_fire;
    assign zte_set     = bus.cdb_valid && (bus.cdb_tag == '0);

    // Head tag is presented combinationally; zero encodes "nothing free".
    always_comb begin
        bus.alloc_valid = !empty || bypass;
        bus.alloc_tag   = '0;
        if (bypass)
            bus.alloc_tag = bus.cdb_tag;
        else if (!empty)
            bus.alloc_tag = mem[head];
        bus.alloc_wdata = {bus.alloc_valid, bus.alloc_tag};
    end

    // Storage, pointers and occupancy; reset and flush rebuild the full list 1..NUM_TAGS.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < NUM_TAGS; i++)
                mem[i] <= TAG_W'(i + 1);
            head       <= '0;
            tail       <= '0;
            free_count <= CNT_W'(NUM_TAGS);
        end else begin
            if (rel_fire) begin
                mem[tail] <= bus.cdb_tag;
                tail      <= ptr_inc(tail);
            end
            if (alloc_fire)
                head <= ptr_inc(head);
            case ({alloc_fire, rel_fire})
                2'b10:   free_count <= free_count - 1'b1;
                2'b01:   free_count <= free_count + 1'b1;
                default: free_count <= free_count;
            endcase
        end
    end

    // Sticky error flags survive a flush; only reset clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_err <= 1'b0;
            zero_tag_err <= 1'b0;
        end else if (!flush) begin
            if (ovf_set)
                overflow_err <= 1'b1;
            if (zte_set)
                zero_tag_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tag_fifo.sv
// tb/tb_tag_fifo.sv - scoreboard bench for tag_fifo against a queue model
module tb_tag_fifo;
    localparam int N = 63;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [6:0] free_count;
    logic       overflow_err;
    logic       zero_tag_err;

    tag_fifo_if #(.TAG_W(6)) bus ();

    tag_fifo #(.TAG_W(6), .NUM_TAGS(N), .CNT_W(7)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .bus          (bus),
        .free_count   (free_count),
        .overflow_err (overflow_err),
        .zero_tag_err (zero_tag_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [5:0] tag;
        logic [6:0] cnt;
        logic       ovf;
        logic       zte;
    } exp_t;

    exp_t sb[$];
    int   fl[$];
    bit   m_ovf;
    bit   m_zte;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_full();
        fl.delete();
        for (int i = 1; i <= N; i++) fl.push_back(i);
    endtask

    // One cycle of stimulus: drive inputs, record expected outputs, advance the model.
    task automatic step(input bit r, input bit f, input bit rq, input bit cv, input int ct);
        exp_t e;
        bit   byp;
        bit   a;
        bit   rl;
        @(posedge clk);
        #1;
        rst = r;
        flush = f;
        bus.alloc_req = rq;
        bus.cdb_valid = cv;
        bus.cdb_tag = 6'(ct);
`ifdef TAG_FIFO_BYPASS_EN
        byp = (fl.size() == 0) && cv && (ct != 0);
`else
        byp = 1'b0;
`endif
        e.v   = (fl.size() != 0) || byp;
        e.tag = byp ? 6'(ct) : ((fl.size() != 0) ? 6'(fl[0]) : 6'd0);
        e.cnt = 7'(fl.size());
        e.ovf = m_ovf;
        e.zte = m_zte;
        sb.push_back(e);
        if (r) begin
            model_full();
            m_ovf = 0;
            m_zte = 0;
        end else if (f) begin
            model_full();
        end else if (!(byp && rq)) begin
            a  = rq && (fl.size() > 0);
            rl = cv && (ct != 0) && ((fl.size() < N) || a);
            if (cv && ct == 0) m_zte = 1;
            if (cv && ct != 0 && fl.size() == N && !a) m_ovf = 1;
            if (a) void'(fl.pop_front());
            if (rl) fl.push_back(ct);
        end
    endtask

    // Monitor: every cycle the DUT presents its outputs, compare against the oldest record.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("alloc_valid", int'(bus.alloc_valid), int'(e.v));
            chk("alloc_tag", int'(bus.alloc_tag), int'(e.tag));
            chk("alloc_wdata", int'(bus.alloc_wdata), int'({e.v, e.tag}));
            chk("free_count", int'(free_count), int'(e.cnt));
            chk("overflow_err", int'(overflow_err), int'(e.ovf));
            chk("zero_tag_err", int'(zero_tag_err), int'(e.zte));
        end
    end

    int perm[N];
    int tmp;
    int j;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.alloc_req = 1'b0;
        bus.cdb_valid = 1'b0;
        bus.cdb_tag = '0;
        repeat (2) @(posedge clk);
        model_full();
        m_ovf = 0;
        m_zte = 0;

        // reset state, then drain all 63 plus one extra request
        step(0, 0, 0, 0, 0);
        repeat (N + 1) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // refill from empty and read back in order
        step(0, 0, 0, 1, 5);
        step(0, 0, 0, 1, 9);
        step(0, 0, 0, 1, 2);
        repeat (3) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0);

        // full: release dropped with overflow, sticky through flush
        step(0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 7);
        step(0, 1, 1, 1, 7);
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        // full with simultaneous allocate: release accepted, no error
        step(0, 0, 1, 1, 7);
        step(0, 0, 0, 0, 0);

        // wrap: drain, then release a scrambled permutation, twice
        for (int i = 0; i < N; i++) perm[i] = i + 1;
        for (int rep = 0; rep < 2; rep++) begin
            for (int i = N - 1; i > 0; i--) begin
                j = $urandom_range(0, i);
                tmp = perm[i];
                perm[i] = perm[j];
                perm[j] = tmp;
            end
            repeat (N + 1) step(0, 0, 1, 0, 0);
            for (int i = 0; i < N; i++) step(0, 0, 0, 1, perm[i]);
        end
        repeat (5) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);

        // mid-operation flush with both handshakes active
        step(0, 1, 1, 1, 33);
        step(0, 0, 0, 0, 0);

        // empty plus same-cycle release and request (bypass when compiled in)
        repeat (N) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 12);
        step(0, 0, 0, 0, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 700) == 0, ($urandom % 250) == 0,
                 ($urandom % 2) == 0, ($urandom % 2) == 0,
                 (($urandom % 16) == 0) ? 0 : int'($urandom_range(1, N)));
        end
        step(0, 0, 0, 0, 0);

        for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d records left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tag_fifo.md
Name: tag_fifo

Overview:
- Free-list of rename tags for the Tomasulo dispatch stage.
- Hands one free tag per cycle to dispatch; dispatch writes {1'b1, tag} into the register status table.
- Reclaims the tag when its result is broadcast on the CDB, closing the allocate/free loop that the status table observes.
- Tag 0 is reserved as the "no producer" encoding and is never issued.

Parameters:
- TAG_W, 6, tag width in bits; must match the status-table tag field.
- NUM_TAGS, 63, number of issuable tags, values 1..NUM_TAGS; must be at most 2^TAG_W-1.
- CNT_W, 7, occupancy counter width; must hold NUM_TAGS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- flush  input  1  synchronous restore of the full free list (mispredict recovery).
- alloc_req  input  1  dispatch consumes alloc_tag this cycle.
- alloc_valid  output  1  a free tag is available.
- alloc_tag  output  TAG_W  current head tag.
- alloc_wdata  output  TAG_W+1  {alloc_valid, alloc_tag}, feeds the status-table write-data port.
- cdb_valid  input  1  CDB broadcast valid.
- cdb_tag  input  TAG_W  tag being retired and released.
- free_count  output  CNT_W  number of tags held.
- overflow_err  output  1  sticky: a release arrived while full.
- zero_tag_err  output  1  sticky: a release arrived with tag 0.

Behaviour:
- Storage: circular buffer of NUM_TAGS entries with TAG_W bits each.
- Pointers: head and tail, each counting modulo NUM_TAGS; both wrap from NUM_TAGS-1 to 0.
- Reset (rst=1 at a clock edge):
  - entry[i] is written with i+1; head=0, tail=0, free_count=NUM_TAGS.
  - overflow_err=0, zero_tag_err=0.
  - Post-reset outputs: alloc_valid=1, alloc_tag=1, alloc_wdata=7'h41.
  - rst has priority over every other input.
- Flush: identical to reset, except overflow_err and zero_tag_err are held. Any alloc_req or cdb_valid in the flush cycle is ignored.
- Outputs are combinational from registered state:
  - alloc_valid = (free_count != 0).
  - alloc_tag = entry[head].
  - When empty, alloc_tag=0 and alloc_wdata=0.
- Allocate:
  - Fires when alloc_req && alloc_valid.
  - Effect: head advances and free_count decrements at the clock edge.
  - Latency 0: the tag is valid in the same cycle it is requested; the next tag is visible the following cycle.
  - alloc_req while empty is ignored: no state change, no error.
- Release:
  - Fires when cdb_valid && cdb_tag != 0 && free_count != NUM_TAGS.
  - Effect: entry[tail] <= cdb_tag, tail advances, free_count increments.
  - Release while full: dropped; overflow_err set.
  - Release with tag 0: dropped; zero_tag_err set.
- Simultaneous allocate and release:
  - Both take effect; free_count is unchanged.
  - When full, the allocate frees a slot within the same cycle, so the release is accepted; overflow_err is not set.
  - When empty, the release is written and the allocate is ignored, unless the optional feature is compiled in.
- Arithmetic:
  - free_count is updated as +1, -1 or 0; it is never left outside 0..NUM_TAGS.
  - Pointer increment: if ptr == NUM_TAGS-1 then 0 else ptr+1 (no power-of-two assumption).
- No duplicate-tag detection is performed; uniqueness is guaranteed by the protocol.

Optional Feature:
- Macro: TAG_FIFO_BYPASS_EN.
- Defined, when free_count==0 and a valid release (cdb_valid, nonzero tag) occurs:
  - alloc_valid=1 and alloc_tag=cdb_tag combinationally in the same cycle.
  - If alloc_req is also asserted, the tag goes straight to dispatch: it is not written, and pointers and free_count are unchanged.
  - If alloc_req is not asserted, normal release behaviour applies.
- Undefined: no bypass; an empty FIFO reports alloc_valid=0 regardless of the CDB.

Test Plan:
- Reset, then idle one cycle -> alloc_valid=1, alloc_tag=1, alloc_wdata=7'h41, free_count=63, both error flags 0.
- alloc_req held for 63 cycles -> tags 1,2,...,63 issued in order; then alloc_valid=0, alloc_tag=0, free_count=0; a 64th alloc_req changes nothing.
- Empty, then release tags 5, 9, 2 on successive cycles -> free_count=3; three allocates return 5, 9, 2 in order.
- Full FIFO, release tag 7 -> dropped, overflow_err=1 (sticky through flush); same cycle with alloc_req=1 -> tag 1 issued, tag 7 accepted, free_count stays 63, overflow_err stays 0.
- Pointer wrap: allocate 63, release 10..72 mapped to valid tags 1..63 in a scrambled order, repeat twice -> FIFO order preserved across the wrap; release of cdb_tag=0 -> zero_tag_err=1, free_count unchanged.
- Mid-operation flush with alloc_req=1 and cdb_valid=1 -> next cycle alloc_tag=1, free_count=63. With TAG_FIFO_BYPASS_EN, empty FIFO plus cdb_tag=12 and alloc_req=1 -> alloc_tag=12 in the same cycle, free_count remains 0.
